// File: rtl/decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// decode_ctrl_stage
//
// Single-entry RV32 decode stage. An accepted instruction word is decoded into
// a registered control bundle that is presented one cycle later with
// out_valid=1 and held stable until the consumer takes it. A SYSTEM
// instruction requests a halt: the stage stops accepting, and once the halt
// bundle is consumed it parks in HALTED until reset. flush squashes the held
// entry and any pending halt (but cannot undo a completed halt).
//
// Parameters
//   EN_MEXT      : 1 = OP with funct7=0000001 decodes as RV32M (mext=1),
//                  0 = it is illegal.
//   EN_FENCE_NOP : 1 = MISC-MEM decodes as a legal no-op, 0 = illegal.
//
// Ports
//   clk           in   clock, all state on posedge
//   rst_n         in   synchronous active-low reset
//   in_valid      in   instr is valid this cycle
//   in_ready      out  stage accepts instr this cycle (combinational)
//   instr[31:0]   in   RV32 instruction word
//   flush         in   squash held entry and pending halt
//   out_valid     out  registered bundle valid
//   out_ready     in   consumer takes bundle this cycle
//   memtoreg, memwrite, branch, regwrite, jump, jumpsrc, alusrc_a_zero
//                 out  registered control bits
//   alusrc[1:0]   out  00=REG 01=IMM 10=PC 11=NPC
//   memsize[2:0]  out  funct3 for LOAD/STORE, else 000
//   mext, illegal, hlt_req  out  registered per-entry flags
//   halted        out  stage permanently halted
// -----------------------------------------------------------------------------
module decode_ctrl_stage #(
    parameter bit EN_MEXT      = 1'b1,
    parameter bit EN_FENCE_NOP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        memtoreg,
    output logic        memwrite,
    output logic        branch,
    output logic        regwrite,
    output logic        jump,
    output logic        jumpsrc,
    output logic        alusrc_a_zero,
    output logic [1:0]  alusrc,
    output logic [2:0]  memsize,
    output logic        mext,
    output logic        illegal,
    output logic        hlt_req,
    output logic        halted
);

    localparam logic [1:0] ALU_SRC_REG = 2'b00;
    localparam logic [1:0] ALU_SRC_IMM = 2'b01;
    localparam logic [1:0] ALU_SRC_PC  = 2'b10;
    localparam logic [1:0] ALU_SRC_NPC = 2'b11;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_HALT_PEND = 2'b01,
        ST_HALTED    = 2'b10
    } state_t;

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       regwrite;
        logic       jump;
        logic       jumpsrc;
        logic       a_zero;
        logic [1:0] alusrc;
        logic [2:0] memsize;
        logic       mext;
        logic       illegal;
        logic       hlt_req;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = ctrl_t'(15'd0);

    // Pure decode of one instruction word; an illegal result carries only the
    // illegal flag so downstream never acts on a partially decoded entry.
    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t      c;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        c   = CTRL_ZERO;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        case (opc)
            OPC_AUIPC: begin
                c.alusrc = ALU_SRC_PC; c.a_zero = 1'b1; c.regwrite = 1'b1;
            end
            OPC_LUI: begin
                c.alusrc = ALU_SRC_IMM; c.a_zero = 1'b1; c.regwrite = 1'b1;
            end
            OPC_OP_IMM: begin
                c.alusrc = ALU_SRC_IMM; c.regwrite = 1'b1;
            end
            OPC_OP: begin
                case (f7)
                    7'b0000000, 7'b0100000: begin
                        c.alusrc = ALU_SRC_REG; c.regwrite = 1'b1;
                    end
                    7'b0000001: begin
                        if (EN_MEXT) begin
                            c.alusrc = ALU_SRC_REG; c.regwrite = 1'b1; c.mext = 1'b1;
                        end else begin
                            c.illegal = 1'b1;
                        end
                    end
                    default: c.illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                c.alusrc = ALU_SRC_REG; c.branch = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                c.alusrc   = ALU_SRC_NPC; c.a_zero = 1'b1; c.jump = 1'b1;
                c.regwrite = 1'b1;
                c.jumpsrc  = (opc == OPC_JALR);
            end
            OPC_LOAD: begin
                case (f3)
                    3'b011, 3'b110, 3'b111: c.illegal = 1'b1;
                    default: begin
                        c.alusrc   = ALU_SRC_IMM; c.regwrite = 1'b1;
                        c.memtoreg = 1'b1;        c.memsize  = f3;
                    end
                endcase
            end
            OPC_STORE: begin
                if (f3 > 3'b010) begin
                    c.illegal = 1'b1;
                end else begin
                    c.alusrc = ALU_SRC_IMM; c.memwrite = 1'b1; c.memsize = f3;
                end
            end
            OPC_MISC_MEM: begin
                // Legal fence decodes to an all-zero bundle: a no-op.
                if (!EN_FENCE_NOP) begin
                    c.illegal = 1'b1;
                end else begin
                    c.illegal = 1'b0;
                end
            end
            OPC_SYSTEM: c.hlt_req = 1'b1;
            default:    c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    logic   out_valid_q, out_valid_d;
    logic   halted_q, halted_d;
    ctrl_t  bundle_q, bundle_d;
    ctrl_t  dec_s;
    logic   accept_s;

    assign dec_s    = decode(instr);
    // rst_n gates in_ready so nothing is taken while reset is being applied.
    assign in_ready = rst_n && (state_q == ST_RUN) && !flush
                      && (!out_valid_q || out_ready);
    assign accept_s = in_valid && in_ready;

    // Next-state: flush beats consume, accept beats consume-only.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (flush) begin
            // Dropped entry is not a consume, so a pending halt is cancelled.
            out_valid_d = 1'b0;
            bundle_d    = CTRL_ZERO;
            if (state_q == ST_HALT_PEND) begin
                state_d = ST_RUN;
            end else begin
                state_d = state_q;
            end
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            bundle_d    = dec_s;
            if (dec_s.hlt_req) begin
                state_d = ST_HALT_PEND;
            end else begin
                state_d = state_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            bundle_d    = CTRL_ZERO;
            if (state_q == ST_HALT_PEND) begin
                state_d = ST_HALTED;
            end else begin
                state_d = state_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
        halted_d = (state_d == ST_HALTED);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            bundle_q    <= CTRL_ZERO;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign halted        = halted_q;
    assign memtoreg      = bundle_q.memtoreg;
    assign memwrite      = bundle_q.memwrite;
    assign branch        = bundle_q.branch;
    assign regwrite      = bundle_q.regwrite;
    assign jump          = bundle_q.jump;
    assign jumpsrc       = bundle_q.jumpsrc;
    assign alusrc_a_zero = bundle_q.a_zero;
    assign alusrc        = bundle_q.alusrc;
    assign memsize       = bundle_q.memsize;
    assign mext          = bundle_q.mext;
    assign illegal       = bundle_q.illegal;
    assign hlt_req       = bundle_q.hlt_req;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_ctrl_stage
//
// Directed testbench for decode_ctrl_stage. Two instances share all inputs:
// dut uses default parameters, dut_nm has EN_MEXT=0 and EN_FENCE_NOP=0.
// Outputs are sampled 1 ns after the rising edge; inputs change there too.
// Bundle vector layout used for comparisons (15 bits, MSB first):
//   illegal mext hlt_req memtoreg memwrite branch regwrite jump jumpsrc
//   a_zero alusrc[1:0] memsize[2:0]
// alusrc encoding: 00=REG 01=IMM 10=PC 11=NPC
// -----------------------------------------------------------------------------
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, memtoreg, memwrite, branch, regwrite;
    logic        jump, jumpsrc, a_zero, mext, illegal, hlt_req, halted;
    logic [1:0]  alusrc;
    logic [2:0]  memsize;

    logic        nm_in_ready, nm_out_valid, nm_memtoreg, nm_memwrite, nm_branch;
    logic        nm_regwrite, nm_jump, nm_jumpsrc, nm_a_zero, nm_mext, nm_illegal;
    logic        nm_hlt_req, nm_halted;
    logic [1:0]  nm_alusrc;
    logic [2:0]  nm_memsize;

    logic [14:0] bus_s, nm_bus_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .memtoreg(memtoreg), .memwrite(memwrite), .branch(branch),
        .regwrite(regwrite), .jump(jump), .jumpsrc(jumpsrc),
        .alusrc_a_zero(a_zero), .alusrc(alusrc), .memsize(memsize),
        .mext(mext), .illegal(illegal), .hlt_req(hlt_req), .halted(halted)
    );

    decode_ctrl_stage #(.EN_MEXT(1'b0), .EN_FENCE_NOP(1'b0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nm_in_ready),
        .instr(instr), .flush(flush), .out_valid(nm_out_valid), .out_ready(out_ready),
        .memtoreg(nm_memtoreg), .memwrite(nm_memwrite), .branch(nm_branch),
        .regwrite(nm_regwrite), .jump(nm_jump), .jumpsrc(nm_jumpsrc),
        .alusrc_a_zero(nm_a_zero), .alusrc(nm_alusrc), .memsize(nm_memsize),
        .mext(nm_mext), .illegal(nm_illegal), .hlt_req(nm_hlt_req), .halted(nm_halted)
    );

    assign bus_s    = {illegal, mext, hlt_req, memtoreg, memwrite, branch, regwrite,
                       jump, jumpsrc, a_zero, alusrc, memsize};
    assign nm_bus_s = {nm_illegal, nm_mext, nm_hlt_req, nm_memtoreg, nm_memwrite,
                       nm_branch, nm_regwrite, nm_jump, nm_jumpsrc, nm_a_zero,
                       nm_alusrc, nm_memsize};

    // Instruction words
    localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_LW    = 32'h0000_A103; // lw   x2,0(x1)
    localparam logic [31:0] I_SW    = 32'h0020_A023; // sw   x2,0(x1)
    localparam logic [31:0] I_BEQ   = 32'h0020_8063; // beq  x1,x2,0
    localparam logic [31:0] I_JALR  = 32'h0001_00E7; // jalr x1,0(x2)
    localparam logic [31:0] I_ECALL = 32'h0000_0073;
    localparam logic [31:0] I_LUI   = 32'h0000_10B7; // lui  x1,1
    localparam logic [31:0] I_BAD   = 32'h0000_007F;
    localparam logic [31:0] I_LD    = 32'h0000_B103; // load funct3=011
    localparam logic [31:0] I_MUL   = 32'h0220_81B3; // mul  x3,x1,x2
    localparam logic [31:0] I_FENCE = 32'h0000_000F;

    // Expected bundles, hand-built field by field
    //                              ill mx hl m2r mw br rw j js az  as     ms
    localparam logic [14:0] E_ZERO  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000};
    localparam logic [14:0] E_ADDI  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,3'b000};
    localparam logic [14:0] E_LW    = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,3'b010};
    localparam logic [14:0] E_SW    = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010};
    localparam logic [14:0] E_BEQ   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000};
    localparam logic [14:0] E_JALR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,2'b11,3'b000};
    localparam logic [14:0] E_HLT   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000};
    localparam logic [14:0] E_LUI   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b01,3'b000};
    localparam logic [14:0] E_ILL   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000};
    localparam logic [14:0] E_MUL   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000};

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] s_ins [5];
    logic [14:0] s_exp [5];
    logic [31:0] il_ins [4];
    logic [14:0] il_exp [4];
    logic [14:0] il_nm  [4];

    initial begin
        s_ins = '{I_ADDI, I_LW, I_SW, I_BEQ, I_JALR};
        s_exp = '{E_ADDI, E_LW, E_SW, E_BEQ, E_JALR};
        il_ins = '{I_BAD, I_LD, I_MUL, I_FENCE};
        il_exp = '{E_ILL, E_ILL, E_MUL, E_ZERO};
        il_nm  = '{E_ILL, E_ILL, E_ILL, E_ILL};

        rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; flush = 1'b0; out_ready = 1'b1;

        // Reset state
        #1;
        check_eq("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        step(); step();
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_bundle", {17'd0, bus_s}, {17'd0, E_ZERO});
        rst_n = 1'b1;
        #1;
        check_eq("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Back-to-back stream, latency 1
        in_valid = 1'b1; instr = s_ins[0];
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("stream_in_ready%0d", i), {31'd0, in_ready}, 32'd1);
            step();
            check_eq($sformatf("stream_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check_eq($sformatf("stream_bundle%0d", i), {17'd0, bus_s}, {17'd0, s_exp[i]});
            if (i < 4) instr = s_ins[i+1];
            else       in_valid = 1'b0;
        end
        step();
        check_eq("stream_drain", {31'd0, out_valid}, 32'd0);

        // Backpressure: bundle held, nothing lost
        out_ready = 1'b0; in_valid = 1'b1; instr = I_ADDI;
        step();
        instr = I_LUI;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("stall_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
            step();
            check_eq($sformatf("stall_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check_eq($sformatf("stall_bundle%0d", i), {17'd0, bus_s}, {17'd0, E_ADDI});
        end
        out_ready = 1'b1;
        #1;
        check_eq("stall_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("stall_next_valid", {31'd0, out_valid}, 32'd1);
        check_eq("stall_next_bundle", {17'd0, bus_s}, {17'd0, E_LUI});
        step();
        check_eq("stall_drain", {31'd0, out_valid}, 32'd0);

        // ECALL with delayed consume -> HALTED
        out_ready = 1'b0; in_valid = 1'b1; instr = I_ECALL;
        step();
        check_eq("ecall_bundle", {17'd0, bus_s}, {17'd0, E_HLT});
        instr = I_ADDI;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) out_ready = 1'b1;
            #1;
            check_eq($sformatf("halt_pend_ready%0d", i), {31'd0, in_ready}, 32'd0);
            step();
        end
        check_eq("halt_after_consume", {31'd0, halted}, 32'd1);
        check_eq("halt_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("halt_in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("halt_flush_ignored", {31'd0, halted}, 32'd1);
        check_eq("halt_no_accept", {31'd0, out_valid}, 32'd0);

        // One-cycle reset while HALTED
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("rst_halted_clear", {31'd0, halted}, 32'd0);
        check_eq("rst_halted_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_halted_bundle", {17'd0, bus_s}, {17'd0, E_ZERO});
        #1;
        check_eq("rst_halted_ready", {31'd0, in_ready}, 32'd1);

        // ECALL then flush racing out_ready
        out_ready = 1'b1; in_valid = 1'b1; instr = I_ECALL;
        step();
        check_eq("ecall2_bundle", {17'd0, bus_s}, {17'd0, E_HLT});
        in_valid = 1'b0; flush = 1'b1;
        #1;
        check_eq("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_not_halted", {31'd0, halted}, 32'd0);
        in_valid = 1'b1; instr = I_ADDI;
        #1;
        check_eq("flush_run_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("flush_next_bundle", {17'd0, bus_s}, {17'd0, E_ADDI});
        step();
        check_eq("flush_stays_run", {31'd0, halted}, 32'd0);

        // Illegal / parameter-dependent decodes on both instances
        in_valid = 1'b1; instr = il_ins[0];
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("ill_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check_eq($sformatf("ill_bundle%0d", i), {17'd0, bus_s}, {17'd0, il_exp[i]});
            check_eq($sformatf("ill_nm_bundle%0d", i), {17'd0, nm_bus_s}, {17'd0, il_nm[i]});
            if (i < 3) instr = il_ins[i+1];
            else       in_valid = 1'b0;
        end
        step();
        check_eq("ill_drain", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_stage.md
DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 SHALL have parameter EN_MEXT, default 1, meaning decode RV32M (R-type, funct7=0000001) and assert mext.
REQ-002 SHALL have parameter EN_FENCE_NOP, default 1, meaning MISC-MEM opcode 0001111 decodes as a legal no-op (0 = illegal).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  instr is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  stage accepts instr this cycle.
REQ-007 SHALL have port instr  input  32  RV32 instruction word.
REQ-008 SHALL have port flush  input  1  squash held entry and pending halt.
REQ-009 SHALL have port out_valid  output  1  registered control bundle valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes bundle this cycle.
REQ-011 SHALL have ports memtoreg, memwrite, branch, regwrite, jump, jumpsrc, alusrc_a_zero  output  1 each  registered control bits.
REQ-012 SHALL have ports alusrc  output  2  and memsize  output  3  registered control fields.
REQ-013 SHALL have ports mext, illegal, hlt_req  output  1 each  registered per-entry flags.
REQ-014 SHALL have port halted  output  1  stage permanently halted.

Function
REQ-015 SHALL accept an instruction when in_valid && in_ready; in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
REQ-016 SHALL present the decoded bundle with out_valid=1 exactly 1 cycle after acceptance; back-to-back throughput 1/cycle.
REQ-017 SHALL hold bundle and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid after out_valid && out_ready unless a new accept occurs the same cycle.
REQ-019 SHALL decode: AUIPC alusrc=ALU_SRC_PC, a_zero=1, regwrite=1; LUI alusrc=IMM, a_zero=1, regwrite=1; OP-IMM alusrc=IMM, regwrite=1; OP alusrc=REG, regwrite=1; BRANCH alusrc=REG, branch=1; JAL/JALR alusrc=NPC, a_zero=1, jump=1, regwrite=1, jumpsrc=(JALR); LOAD alusrc=IMM, regwrite=1, memtoreg=1; STORE alusrc=IMM, memwrite=1; SYSTEM hlt_req=1.
REQ-020 SHALL drive every bit not listed for an opcode to 0 (no X); memsize = funct3 for LOAD/STORE, else 000.
REQ-021 SHALL flag illegal=1 with all other bits 0 for: unknown opcode; LOAD funct3 in {011,110,111}; STORE funct3 > 010; MISC-MEM when EN_FENCE_NOP=0; OP with funct7=0000001 when EN_MEXT=0; OP funct7 not in {0000000,0100000,0000001}.
REQ-022 SHALL set mext=1 for OP with funct7=0000001 when EN_MEXT=1; other bits as OP.
REQ-023 SHALL implement states RUN, HALT_PEND, HALTED.
REQ-024 SHALL transition RUN->HALT_PEND on accepting a SYSTEM instruction; in_ready=0 in HALT_PEND.
REQ-025 SHALL transition HALT_PEND->HALTED when the hlt_req bundle is consumed (out_valid && out_ready).
REQ-026 SHALL in HALTED hold in_ready=0, out_valid=0, halted=1 until reset.
REQ-027 SHALL on flush: out_valid=0 next cycle, no accept that cycle; HALT_PEND->RUN; flush in HALTED has no effect.
REQ-028 SHALL give flush priority over out_ready in the same cycle (entry dropped, not counted consumed; HALTED not entered).

Reset
REQ-029 SHALL on posedge clk with rst_n=0: state=RUN, out_valid=0, halted=0, all control outputs and flags 0, memsize=000.
REQ-030 SHALL treat reset mid-operation (including HALT_PEND/HALTED) identically to REQ-029; in_ready=0 while rst_n=0.

Verification
REQ-031 SHALL cover: stream ADDI, LW (funct3=010), SW, BEQ, JALR with out_ready=1 -> one bundle per cycle, latency 1, LW memsize=010 memtoreg=1, JALR jumpsrc=1.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> bundle stable, in_ready=0, no instruction lost after out_ready=1.
REQ-033 SHALL cover: ECALL (0x00000073) accepted, out_ready=0 two cycles then 1 -> in_ready=0 throughout, halted=1 the cycle after consume.
REQ-034 SHALL cover: ECALL accepted then flush with out_ready=1 same cycle -> out_valid=0, state RUN, halted=0, next ADDI accepted.
REQ-035 SHALL cover: opcode 0x0000007F and LD (funct3=011) -> illegal=1, all other bits 0; MUL with EN_MEXT=1 -> mext=1, EN_MEXT=0 -> illegal=1.
REQ-036 SHALL cover: rst_n=0 for one cycle while HALTED -> all outputs 0, in_ready=1 next cycle.
